// File: rtl/ysyx_23060332_lsu.sv
// Load-store unit: single-outstanding bus master between execute and writeback.
// Stores are lane-replicated with byte strobes; loads are extracted and sign/zero extended.
module ysyx_23060332_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [2:0]  in_func3,
    input  logic [31:0] in_alu_result,
    input  logic [4:0]  in_waddr,
    input  logic        in_reg_wen,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_wstrb,
    input  logic        bus_resp_valid,
    input  logic [31:0] bus_resp_rdata,
    input  logic        bus_resp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_waddr,
    output logic [31:0] out_wdata,
    output logic        out_reg_wen,
    output logic        out_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [7:0]  cnt;
    logic        ld_q;
    logic [1:0]  off_q;
    logic [2:0]  func3_q;
    logic        reg_wen_q;

    logic        mem_op;
    logic        f3_bad;
    logic        misal;
    logic        fault;
    logic [31:0] st_data;
    logic [3:0]  st_strb;
    logic [31:0] shifted;
    logic [31:0] ld_data;

    assign in_ready = (state == IDLE);

    always_comb begin
        mem_op = in_ren | in_wen;
        if (in_ren)
            f3_bad = (in_func3 == 3'b011) || (in_func3[2:1] == 2'b11);
        else
            f3_bad = in_func3[2] || (in_func3[1:0] == 2'b11);
        misal = ((in_func3[1:0] == 2'b01) && in_addr[0]) ||
                ((in_func3[1:0] == 2'b10) && (in_addr[1:0] != 2'b00));
        fault = f3_bad | misal;
    end

    always_comb begin
        st_data = in_wdata;
        st_strb = 4'b1111;
        case (in_func3[1:0])
            2'b00: begin
                st_data = {4{in_wdata[7:0]}};
                st_strb = 4'b0001 << in_addr[1:0];
            end
            2'b01: begin
                st_data = {2{in_wdata[15:0]}};
                st_strb = 4'b0011 << in_addr[1:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = bus_resp_rdata >> {off_q, 3'b000};
        case (func3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  ld_data = {24'd0, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  ld_data = {16'd0, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (mem_op && !fault) ? REQ : DONE;
            REQ:  if (bus_req_ready) state_nxt = WAIT;
            WAIT: if (bus_resp_valid || cnt == CNT_LAST) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            ld_q          <= 1'b0;
            off_q         <= '0;
            func3_q       <= '0;
            reg_wen_q     <= 1'b0;
            bus_req_valid <= 1'b0;
            bus_req_we    <= 1'b0;
            bus_req_addr  <= '0;
            bus_req_wdata <= '0;
            bus_req_wstrb <= '0;
            out_valid     <= 1'b0;
            out_waddr     <= '0;
            out_wdata     <= '0;
            out_reg_wen   <= 1'b0;
            out_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    ld_q      <= in_ren;
                    off_q     <= in_addr[1:0];
                    func3_q   <= in_func3;
                    reg_wen_q <= in_reg_wen;
                    out_waddr <= in_waddr;
                    if (!mem_op) begin
                        out_valid   <= 1'b1;
                        out_wdata   <= in_alu_result;
                        out_reg_wen <= in_reg_wen;
                        out_err     <= 1'b0;
                    end else if (fault) begin
                        out_valid   <= 1'b1;
                        out_wdata   <= '0;
                        out_reg_wen <= 1'b0;
                        out_err     <= 1'b1;
                    end else begin
                        bus_req_valid <= 1'b1;
                        bus_req_we    <= in_wen;
                        bus_req_addr  <= {in_addr[31:2], 2'b00};
                        bus_req_wdata <= in_wen ? st_data : '0;
                        bus_req_wstrb <= in_wen ? st_strb : '0;
                    end
                end
                REQ: if (bus_req_ready) begin
                    bus_req_valid <= 1'b0;
                    cnt           <= '0;
                end
                // A response in the final counted cycle still wins over the timeout.
                WAIT: if (bus_resp_valid) begin
                    out_valid   <= 1'b1;
                    out_err     <= bus_resp_err;
                    out_reg_wen <= ld_q & reg_wen_q & ~bus_resp_err;
                    out_wdata   <= (ld_q && !bus_resp_err) ? ld_data : '0;
                end else if (cnt == CNT_LAST) begin
                    out_valid   <= 1'b1;
                    out_err     <= 1'b1;
                    out_reg_wen <= 1'b0;
                    out_wdata   <= '0;
                end else begin
                    cnt <= cnt + 8'd1;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    out_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
// Self-checking bench for ysyx_23060332_lsu: directed scenarios plus randomized ops
// checked against a behavioural model of the load/store rules.
module tb_ysyx_23060332_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_ren, in_wen, in_reg_wen;
    logic [31:0] in_addr, in_wdata, in_alu_result;
    logic [2:0]  in_func3;
    logic [4:0]  in_waddr;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_wstrb;
    logic        bus_resp_valid, bus_resp_err;
    logic [31:0] bus_resp_rdata;
    logic        out_valid, out_ready, out_reg_wen, out_err;
    logic [4:0]  out_waddr;
    logic [31:0] out_wdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ysyx_23060332_lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ren(in_ren), .in_wen(in_wen),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_func3(in_func3),
        .in_alu_result(in_alu_result), .in_waddr(in_waddr), .in_reg_wen(in_reg_wen),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_req_we(bus_req_we),
        .bus_req_addr(bus_req_addr), .bus_req_wdata(bus_req_wdata), .bus_req_wstrb(bus_req_wstrb),
        .bus_resp_valid(bus_resp_valid), .bus_resp_rdata(bus_resp_rdata), .bus_resp_err(bus_resp_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_waddr(out_waddr),
        .out_wdata(out_wdata), .out_reg_wen(out_reg_wen), .out_err(out_err)
    );

    // Observations of the most recent operation
    logic        o_req_seen, o_req_stable, o_we, o_valid, o_reg_wen, o_err;
    logic [31:0] o_addr, o_bwdata, o_wdata;
    logic [3:0]  o_wstrb;
    logic [4:0]  o_waddr;
    int          o_req_hold, o_wait, o_lat;

    task automatic drive_op(input logic ren, input logic wen, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] f3,
                            input logic [31:0] alu, input logic [4:0] wa, input logic rw,
                            input int req_delay, input int resp_delay,
                            input logic [31:0] rdata, input logic rerr, input logic respond);
        int cyc;
        bit hs_pending;
        in_valid = 1'b1; in_ren = ren; in_wen = wen; in_addr = addr; in_wdata = wdata;
        in_func3 = f3; in_alu_result = alu; in_waddr = wa; in_reg_wen = rw;
        @(posedge clk); @(negedge clk);
        // Scramble inputs after acceptance so results must come from latched copies
        in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_addr = $urandom; in_wdata = $urandom;
        in_func3 = 3'($urandom); in_alu_result = $urandom; in_waddr = 5'($urandom);
        in_reg_wen = 1'($urandom);
        o_req_seen = 1'b0; o_req_stable = 1'b1; o_req_hold = 0; o_wait = 0; o_lat = 1;
        hs_pending = 1'b0; cyc = 0;
        while (!out_valid && cyc < 100) begin
            bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
            if (bus_req_valid) begin
                if (!o_req_seen) begin
                    o_addr = bus_req_addr; o_bwdata = bus_req_wdata;
                    o_wstrb = bus_req_wstrb; o_we = bus_req_we;
                end else if (o_addr !== bus_req_addr || o_bwdata !== bus_req_wdata ||
                             o_wstrb !== bus_req_wstrb || o_we !== bus_req_we) begin
                    o_req_stable = 1'b0;
                end
                o_req_seen = 1'b1;
                o_req_hold++;
                if (o_req_hold > req_delay) begin
                    bus_req_ready = 1'b1;
                    hs_pending = 1'b1;
                end
            end else if (hs_pending) begin
                o_wait++;
                if (respond && o_wait == resp_delay + 1) begin
                    bus_resp_valid = 1'b1; bus_resp_rdata = rdata; bus_resp_err = rerr;
                end
            end
            @(posedge clk); @(negedge clk);
            cyc++; o_lat++;
        end
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_err = 1'b0;
        bus_resp_rdata = $urandom;
        o_valid = out_valid; o_wdata = out_wdata; o_waddr = out_waddr;
        o_reg_wen = out_reg_wen; o_err = out_err;
    endtask

    task automatic wb_accept();
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    // Behavioural reference: derives everything from access size/offset arithmetic
    function automatic void model(input logic ren, input logic wen, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [2:0] f3,
                                  input logic [31:0] alu, input logic rw,
                                  input logic [31:0] rdata, input logic rerr, input logic respond,
                                  output logic e_req, output logic e_we,
                                  output logic [31:0] e_baddr, output logic [31:0] e_bwdata,
                                  output logic [3:0] e_wstrb, output logic [31:0] e_wdata,
                                  output logic e_rw, output logic e_err);
        int unsigned off, size;
        bit sgn, legal;
        longint v;
        off = addr % 4;
        e_req = 0; e_we = 0; e_baddr = 0; e_bwdata = 0; e_wstrb = 0; e_wdata = 0;
        e_rw = 0; e_err = 0;
        if (!ren && !wen) begin
            e_wdata = alu; e_rw = rw;
            return;
        end
        size = 4; sgn = 0; legal = 1;
        case (f3)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: size = 4;
            3'd4: begin size = 1; legal = ren; end
            3'd5: begin size = 2; legal = ren; end
            default: legal = 0;
        endcase
        if (!legal || (off % size) != 0) begin
            e_err = 1;
            return;
        end
        e_req = 1; e_we = wen; e_baddr = addr - off;
        if (wen) begin
            e_wstrb = 4'(((1 << size) - 1) << off);
            if (size == 1)      e_bwdata = (wdata & 32'hFF) * 32'h01010101;
            else if (size == 2) e_bwdata = (wdata & 32'hFFFF) * 32'h00010001;
            else                e_bwdata = wdata;
        end
        if (!respond || rerr) begin
            e_err = 1;
            return;
        end
        if (ren) begin
            v = (longint'(rdata) >> (8 * off)) & ((64'd1 << (8 * size)) - 1);
            if (sgn && size < 4 && v >= (64'd1 << (8 * size - 1))) v = v - (64'd1 << (8 * size));
            e_wdata = 32'(v);
            e_rw = rw;
        end
    endfunction

    task automatic test_reset();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (bus_req_valid !== 1'b0 || bus_req_we !== 1'b0 || bus_req_addr !== 32'd0 ||
                     bus_req_wdata !== 32'd0 || bus_req_wstrb !== 4'd0) begin
            bad++; $display("FAIL reset_bus got v=%b we=%b a=%h d=%h s=%b want all zero",
                            bus_req_valid, bus_req_we, bus_req_addr, bus_req_wdata, bus_req_wstrb); end
        total++; if (out_valid !== 1'b0 || out_waddr !== 5'd0 || out_wdata !== 32'd0 ||
                     out_reg_wen !== 1'b0 || out_err !== 1'b0) begin
            bad++; $display("FAIL reset_out got v=%b a=%0d d=%h w=%b e=%b want all zero",
                            out_valid, out_waddr, out_wdata, out_reg_wen, out_err); end
    endtask

    task automatic test_passthrough();
        drive_op(0, 0, 32'h0, 32'h0, 3'd0, 32'h1234, 5'd5, 1, 0, 0, 32'h0, 0, 1);
        total++; if (o_lat !== 1) begin bad++; $display("FAIL pass_latency got=%0d want=1", o_lat); end
        total++; if (o_valid !== 1'b1 || o_wdata !== 32'h1234 || o_waddr !== 5'd5 || o_reg_wen !== 1'b1 || o_err !== 1'b0) begin
            bad++; $display("FAIL pass_result got v=%b d=%h a=%0d w=%b e=%b want 1 00001234 5 1 0",
                            o_valid, o_wdata, o_waddr, o_reg_wen, o_err); end
        total++; if (o_req_seen !== 1'b0) begin bad++; $display("FAIL pass_no_bus got=%b want=0", o_req_seen); end
        wb_accept();
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL pass_release got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_load_byte();
        drive_op(1, 0, 32'h80000003, 32'h0, 3'b000, 32'h0, 5'd7, 1, 3, 1, 32'h80FF0000, 0, 1);
        total++; if (o_req_hold !== 4 || o_req_stable !== 1'b1 || o_addr !== 32'h80000000) begin
            bad++; $display("FAIL lb_request got hold=%0d stable=%b addr=%h want 4 1 80000000",
                            o_req_hold, o_req_stable, o_addr); end
        total++; if (o_we !== 1'b0 || o_wstrb !== 4'b0000) begin
            bad++; $display("FAIL lb_we_strb got we=%b s=%b want 0 0000", o_we, o_wstrb); end
        total++; if (o_wdata !== 32'hFFFFFF80 || o_reg_wen !== 1'b1 || o_err !== 1'b0 || o_waddr !== 5'd7) begin
            bad++; $display("FAIL lb_result got d=%h w=%b e=%b a=%0d want ffffff80 1 0 7",
                            o_wdata, o_reg_wen, o_err, o_waddr); end
        wb_accept();
        drive_op(1, 0, 32'h80000003, 32'h0, 3'b100, 32'h0, 5'd7, 1, 3, 0, 32'h80FF0000, 0, 1);
        total++; if (o_wdata !== 32'h00000080 || o_err !== 1'b0) begin
            bad++; $display("FAIL lbu_result got d=%h e=%b want 00000080 0", o_wdata, o_err); end
        wb_accept();
    endtask

    task automatic test_store_half();
        drive_op(0, 1, 32'h80000002, 32'hDEADBEEF, 3'b001, 32'h55, 5'd9, 1, 0, 0, 32'h0, 0, 1);
        total++; if (o_bwdata !== 32'hBEEFBEEF || o_wstrb !== 4'b1100 || o_we !== 1'b1 || o_addr !== 32'h80000000) begin
            bad++; $display("FAIL sh_request got d=%h s=%b we=%b a=%h want beefbeef 1100 1 80000000",
                            o_bwdata, o_wstrb, o_we, o_addr); end
        total++; if (o_valid !== 1'b1 || o_reg_wen !== 1'b0 || o_wdata !== 32'd0 || o_err !== 1'b0) begin
            bad++; $display("FAIL sh_done got v=%b w=%b d=%h e=%b want 1 0 0 0", o_valid, o_reg_wen, o_wdata, o_err); end
        wb_accept();
    endtask

    task automatic test_faults();
        drive_op(1, 0, 32'h80000001, 32'h0, 3'b010, 32'h0, 5'd3, 1, 0, 0, 32'h0, 0, 1);
        total++; if (o_req_seen !== 1'b0 || o_err !== 1'b1 || o_reg_wen !== 1'b0) begin
            bad++; $display("FAIL lw_misaligned got req=%b e=%b w=%b want 0 1 0", o_req_seen, o_err, o_reg_wen); end
        wb_accept();
        total++; if (out_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b want=0", out_err); end
        drive_op(1, 0, 32'h80000002, 32'h0, 3'b101, 32'h0, 5'd3, 1, 0, 0, 32'hA5A50000, 0, 1);
        total++; if (o_wdata !== 32'h0000A5A5 || o_err !== 1'b0 || o_reg_wen !== 1'b1) begin
            bad++; $display("FAIL lhu_result got d=%h e=%b w=%b want 0000a5a5 0 1", o_wdata, o_err, o_reg_wen); end
        wb_accept();
        drive_op(1, 0, 32'h80000004, 32'h0, 3'b010, 32'h0, 5'd3, 1, 1, 1, 32'h12345678, 1, 1);
        total++; if (o_err !== 1'b1 || o_reg_wen !== 1'b0) begin
            bad++; $display("FAIL bus_err got e=%b w=%b want 1 0", o_err, o_reg_wen); end
        wb_accept();
    endtask

    task automatic test_timeout();
        logic [31:0] held;
        drive_op(1, 0, 32'h80000010, 32'h0, 3'b010, 32'h0, 5'd4, 1, 0, 0, 32'h0, 0, 0);
        total++; if (o_wait !== 4 || o_err !== 1'b1 || o_reg_wen !== 1'b0 || o_valid !== 1'b1) begin
            bad++; $display("FAIL timeout got wait=%0d e=%b w=%b v=%b want 4 1 0 1", o_wait, o_err, o_reg_wen, o_valid); end
        held = out_wdata;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'hCAFEF00D;
        @(posedge clk); @(negedge clk);
        bus_resp_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_reg_wen !== 1'b0 || out_wdata !== held) begin
            bad++; $display("FAIL stray_in_done got v=%b e=%b w=%b d=%h want 1 1 0 %h",
                            out_valid, out_err, out_reg_wen, out_wdata, held); end
        wb_accept();
        bus_resp_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_resp_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL stray_in_idle got v=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_backpressure();
        bit stable;
        drive_op(0, 0, 32'h0, 32'h0, 3'd0, 32'hA1B2C3D4, 5'd17, 1, 0, 0, 32'h0, 0, 1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_wdata !== 32'hA1B2C3D4 ||
                out_waddr !== 5'd17 || out_reg_wen !== 1'b1) stable = 1'b0;
        end
        total++; if (stable !== 1'b1) begin
            bad++; $display("FAIL backpressure got stable=%b v=%b rdy=%b d=%h want stable=1",
                            stable, out_valid, in_ready, out_wdata); end
        wb_accept();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_ren = 1'b1; in_wen = 1'b0; in_addr = 32'h80000020; in_func3 = 3'b010;
        in_waddr = 5'd1; in_reg_wen = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_ren = 1'b0;
        total++; if (bus_req_valid !== 1'b1) begin bad++; $display("FAIL rst_req_pre got=%b want=1", bus_req_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (bus_req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_in_req got v=%b ov=%b rdy=%b want 0 0 1", bus_req_valid, out_valid, in_ready); end
        @(negedge clk); rst_n = 1'b1;
        in_valid = 1'b1; in_ren = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_ren = 1'b0;
        bus_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        total++; if (bus_req_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_in_wait got v=%b ov=%b rdy=%b want 0 0 1", bus_req_valid, out_valid, in_ready); end
        @(negedge clk); rst_n = 1'b1;
        bus_resp_valid = 1'b1; bus_resp_rdata = 32'h11111111;
        @(posedge clk); @(negedge clk);
        bus_resp_valid = 1'b0;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rst_discard got ov=%b rdy=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_random();
        logic ren, wen, rw, rerr, respond;
        logic [31:0] addr, wdata, alu, rdata;
        logic [2:0] f3;
        logic [4:0] wa;
        int kind, rqd, rsd;
        logic e_req, e_we, e_rw, e_err;
        logic [31:0] e_baddr, e_bwdata, e_wdata;
        logic [3:0] e_wstrb;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 2);
            ren = (kind == 1); wen = (kind == 2);
            addr = $urandom; wdata = $urandom; alu = $urandom; rdata = $urandom;
            f3 = 3'($urandom); wa = 5'($urandom); rw = 1'($urandom);
            rqd = $urandom_range(0, 3); rsd = $urandom_range(0, 2);
            rerr = ($urandom_range(0, 7) == 0);
            respond = ($urandom_range(0, 9) != 0);
            model(ren, wen, addr, wdata, f3, alu, rw, rdata, rerr, respond,
                  e_req, e_we, e_baddr, e_bwdata, e_wstrb, e_wdata, e_rw, e_err);
            drive_op(ren, wen, addr, wdata, f3, alu, wa, rw, rqd, rsd, rdata, rerr, respond);
            total++; if (o_valid !== 1'b1 || o_err !== e_err || o_reg_wen !== e_rw || o_waddr !== wa) begin
                bad++; $display("FAIL rnd%0d_status got v=%b e=%b w=%b a=%0d want 1 %b %b %0d (ren=%b wen=%b f3=%b addr=%h)",
                                n, o_valid, o_err, o_reg_wen, o_waddr, e_err, e_rw, wa, ren, wen, f3, addr); end
            if (!e_err) begin
                total++; if (o_wdata !== e_wdata) begin
                    bad++; $display("FAIL rnd%0d_wdata got=%h want=%h (ren=%b f3=%b addr=%h rdata=%h)",
                                    n, o_wdata, e_wdata, ren, f3, addr, rdata); end
            end
            total++; if (o_req_seen !== e_req) begin
                bad++; $display("FAIL rnd%0d_req_seen got=%b want=%b", n, o_req_seen, e_req); end
            if (e_req && o_req_seen) begin
                total++; if (o_addr !== e_baddr || o_we !== e_we || o_wstrb !== e_wstrb || o_req_stable !== 1'b1 ||
                             (e_we && o_bwdata !== e_bwdata)) begin
                    bad++; $display("FAIL rnd%0d_req got a=%h we=%b s=%b d=%h st=%b want %h %b %b %h 1",
                                    n, o_addr, o_we, o_wstrb, o_bwdata, o_req_stable, e_baddr, e_we, e_wstrb, e_bwdata); end
            end
            wb_accept();
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ren = 1'b0; in_wen = 1'b0; in_addr = '0; in_wdata = '0;
        in_func3 = '0; in_alu_result = '0; in_waddr = '0; in_reg_wen = 1'b0;
        bus_req_ready = 1'b0; bus_resp_valid = 1'b0; bus_resp_rdata = '0; bus_resp_err = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_passthrough();
        test_load_byte();
        test_store_half();
        test_faults();
        test_timeout();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
